picomips_seq_decoder: RTL

Parametrised, stateful successor to the picoMIPS combinational instruction decoder. It decodes the instruction opcode into PC, ALU, immediate-mux and register-file controls. It adds three things the combinational decoder lacks: a registered condition-flag register updated only by flag-setting instructions, a multi-cycle MUL/MULI sequencer that stalls the PC, and a sticky illegal-opcode flag. It sits between program memory (opcode field) and the PC, ALU, immediate mux and register file.

---
 rtl/picomips_seq_decoder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/picomips_seq_decoder.sv
// rtl/picomips_seq_decoder.sv - picoMIPS decoder with flag register, multi-cycle MUL sequencer and sticky illegal flag
module picomips_seq_decoder #(
    parameter int OPW        = 6,
    parameter int FNW        = 3,
    parameter int FLW        = 4,
    parameter int MUL_CYCLES = 4
) (
    input  logic           clk,
    input  logic           nReset,
    input  logic [OPW-1:0] opcode,
    input  logic [FLW-1:0] flags,
    output logic           PCincr,
    output logic           PCabsbranch,
    output logic           PCrelbranch,
    output logic [FNW-1:0] ALUfunc,
    output logic           imm,
    output logic           w,
    output logic           mul_start,
    output logic           stall,
    output logic [FLW-1:0] flags_q,
    output logic           illegal
);

    localparam int CW = $clog2(MUL_CYCLES);

    localparam logic [OPW-1:0] OP_NOP  = OPW'(6'h00);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(6'h02);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(6'h03);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(6'h04);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6'h0A);
    localparam logic [OPW-1:0] OP_SUBI = OPW'(6'h0B);
    localparam logic [OPW-1:0] OP_MULI = OPW'(6'h0C);
    localparam logic [OPW-1:0] OP_J    = OPW'(6'h10);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'h11);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(6'h12);
    localparam logic [OPW-1:0] OP_BGE  = OPW'(6'h13);
    localparam logic [OPW-1:0] OP_BLO  = OPW'(6'h14);

    typedef enum logic {DECODE, MUL_WAIT} state_t;

    state_t         state, state_d;
    logic [CW-1:0]  cnt, cnt_d;
    logic           muli_q, muli_d;
    logic           flag_we;
    logic           dec_illegal;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state   <= DECODE;
            cnt     <= '0;
            muli_q  <= 1'b0;
            flags_q <= '0;
            illegal <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            muli_q <= muli_d;
            if (flag_we)
                flags_q <= flags;
            if (dec_illegal)
                illegal <= 1'b1;
        end
    end

    always_comb begin
        PCincr      = 1'b1;
        PCabsbranch = 1'b0;
        PCrelbranch = 1'b0;
        ALUfunc     = opcode[FNW-1:0];
        imm         = 1'b0;
        w           = 1'b0;
        mul_start   = 1'b0;
        stall       = 1'b0;
        flag_we     = 1'b0;
        dec_illegal = 1'b0;
        state_d     = state;
        cnt_d       = cnt;
        muli_d      = muli_q;
        case (state)
            DECODE: begin
                case (opcode)
                    OP_NOP: ;
                    OP_ADD, OP_SUB: begin
                        w       = 1'b1;
                        flag_we = 1'b1;
                    end
                    OP_ADDI, OP_SUBI: begin
                        w       = 1'b1;
                        imm     = 1'b1;
                        flag_we = 1'b1;
                    end
                    OP_MUL, OP_MULI: begin
                        mul_start = 1'b1;
                        stall     = 1'b1;
                        PCincr    = 1'b0;
                        imm       = (opcode == OP_MULI);
                        muli_d    = (opcode == OP_MULI);
                        cnt_d     = CW'(MUL_CYCLES - 2);
                        state_d   = MUL_WAIT;
                    end
                    OP_J: begin
                        PCabsbranch = 1'b1;
                        PCincr      = 1'b0;
                    end
                    OP_BEQ, OP_BNE, OP_BGE, OP_BLO: begin
                        if ((opcode == OP_BEQ &&  flags_q[1]) ||
                            (opcode == OP_BNE && !flags_q[1]) ||
                            (opcode == OP_BGE && !flags_q[2]) ||
                            (opcode == OP_BLO &&  flags_q[0])) begin
                            PCrelbranch = 1'b1;
                            PCincr      = 1'b0;
                        end
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            MUL_WAIT: begin
                // Opcode upper bits are not trusted here; MULI-ness was latched at launch.
                imm = muli_q;
                if (cnt != '0) begin
                    stall  = 1'b1;
                    PCincr = 1'b0;
                    cnt_d  = cnt - CW'(1);
                end else begin
                    w       = 1'b1;
                    flag_we = 1'b1;
                    state_d = DECODE;
                end
            end
            default: state_d = DECODE;
        endcase
    end

endmodule
